// File: rtl/wb_arbiter.sv
// Writeback arbiter for the integer register file: merges pipeline results with
// buffered multi-cycle results and tracks registers owed by the multi-cycle unit.
module wb_arbiter #(
  parameter  int REG_WIDTH     = 32,
  parameter  int FILE_DEPTH    = 32,
  parameter  int MC_FIFO_DEPTH = 2,
  parameter  int STARVE_LIMIT  = 4,
  localparam int ADDR_WIDTH    = $clog2(FILE_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_pipe_valid,
  input  logic [ADDR_WIDTH-1:0] i_pipe_rd,
  input  logic [REG_WIDTH-1:0]  i_pipe_data,
  output logic                  o_pipe_stall,
  input  logic                  i_mc_valid,
  output logic                  o_mc_ready,
  input  logic [ADDR_WIDTH-1:0] i_mc_rd,
  input  logic [REG_WIDTH-1:0]  i_mc_data,
  input  logic                  i_mc_issue,
  input  logic [ADDR_WIDTH-1:0] i_mc_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  output logic                  o_rs_busy,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [REG_WIDTH-1:0]  o_wr_data,
  output logic                  o_err
);

  localparam int PTR_W = $clog2(MC_FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] fifo_rd_q   [MC_FIFO_DEPTH];
  logic [REG_WIDTH-1:0]  fifo_data_q [MC_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_rd_d   [MC_FIFO_DEPTH];
  logic [REG_WIDTH-1:0]  fifo_data_d [MC_FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic [FILE_DEPTH-1:0] busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  err_q, err_d;
  logic                  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_rd_q, hold_rd_d;
  logic [REG_WIDTH-1:0]  hold_data_q, hold_data_d;

  logic                  empty, full, push, pop, pipe_sel;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [REG_WIDTH-1:0]  head_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_rd   = fifo_rd_q[rd_ptr_q[PTR_W-1:0]];
  assign head_data = fifo_data_q[rd_ptr_q[PTR_W-1:0]];

  assign o_mc_ready   = ~full;
  assign o_pipe_stall = stall_q;
  assign o_rs_busy    = busy_q[i_rs1] | busy_q[i_rs2];
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_err        = err_q;

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    starve_d    = starve_q;
    stall_d     = 1'b0;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    push     = i_mc_valid & ~full;
    pipe_sel = i_pipe_valid & ~stall_q;
    pop      = ~pipe_sel & ~empty;

    if (pipe_sel) begin
      wr_en_d   = (i_pipe_rd != '0);
      wr_addr_d = i_pipe_rd;
      wr_data_d = i_pipe_data;
    end else if (pop) begin
      wr_en_d   = (head_rd != '0);
      wr_addr_d = head_rd;
      wr_data_d = head_data;
    end

    if (push) begin
      fifo_rd_d[wr_ptr_q[PTR_W-1:0]]   = i_mc_rd;
      fifo_data_d[wr_ptr_q[PTR_W-1:0]] = i_mc_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Reaching the limit forces one stall cycle in which the FIFO head drains.
    if (pop || empty) begin
      starve_d = '0;
    end else if (pipe_sel) begin
      if (starve_q == CNT_W'(STARVE_LIMIT - 1)) begin
        starve_d = '0;
        stall_d  = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end

    if (pop) busy_d[head_rd] = 1'b0;
    if (i_mc_issue && (i_mc_issue_rd != '0)) busy_d[i_mc_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    // Results for rd=0 are never tracked as busy, so they are exempt from the push check.
    err_d = err_q
          | (i_mc_issue && busy_q[i_mc_issue_rd])
          | (push && (i_mc_rd != '0) && !busy_q[i_mc_rd])
          | (hold_q && i_mc_valid && ((i_mc_rd != hold_rd_q) || (i_mc_data != hold_data_q)));

    hold_d      = i_mc_valid & full;
    hold_rd_d   = i_mc_rd;
    hold_data_d = i_mc_data;
  end

  always_ff @(posedge i_clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
    hold_rd_q   <= hold_rd_d;
    hold_data_q <= hold_data_d;
    if (!i_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: each task drives one scenario and checks
// hand-computed write-port, stall, busy and error values.
module tb_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_pipe_valid;
  logic [4:0]  i_pipe_rd;
  logic [31:0] i_pipe_data;
  logic        o_pipe_stall;
  logic        i_mc_valid;
  logic        o_mc_ready;
  logic [4:0]  i_mc_rd;
  logic [31:0] i_mc_data;
  logic        i_mc_issue;
  logic [4:0]  i_mc_issue_rd;
  logic [4:0]  i_rs1, i_rs2;
  logic        o_rs_busy;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_err;

  int vectors = 0;
  int miscompares = 0;

  wb_arbiter dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_pipe_valid(i_pipe_valid), .i_pipe_rd(i_pipe_rd), .i_pipe_data(i_pipe_data),
    .o_pipe_stall(o_pipe_stall),
    .i_mc_valid(i_mc_valid), .o_mc_ready(o_mc_ready), .i_mc_rd(i_mc_rd), .i_mc_data(i_mc_data),
    .i_mc_issue(i_mc_issue), .i_mc_issue_rd(i_mc_issue_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .o_rs_busy(o_rs_busy),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_pipe_valid = 0; i_pipe_rd = 0; i_pipe_data = 0;
    i_mc_valid = 0; i_mc_rd = 0; i_mc_data = 0;
    i_mc_issue = 0; i_mc_issue_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    i_mc_issue = 1; i_mc_issue_rd = rd;
    step();
    i_mc_issue = 0;
  endtask

  task automatic test_reset();
    idle(); i_rs1 = 0; i_rs2 = 0;
    i_reset_n = 0;
    step(); step();
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data} !== 38'd0) begin
      $display("FAIL reset_wr: got %b/%h/%h expected 0/00/00000000", o_wr_en, o_wr_addr, o_wr_data);
      miscompares++;
    end
    vectors++;
    if ({o_pipe_stall, o_err, o_mc_ready, o_rs_busy} !== 4'b0010) begin
      $display("FAIL reset_flags: got stall/err/ready/busy=%b expected 0010",
               {o_pipe_stall, o_err, o_mc_ready, o_rs_busy});
      miscompares++;
    end
    i_reset_n = 1;
    step();
  endtask

  task automatic test_pipe_write();
    i_pipe_valid = 1; i_pipe_rd = 3; i_pipe_data = 32'hDEADBEEF;
    step();
    i_pipe_valid = 0;
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      $display("FAIL pipe_write: got %b/%h/%h expected 1/03/deadbeef", o_wr_en, o_wr_addr, o_wr_data);
      miscompares++;
    end
    step();
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b0, 5'd3, 32'hDEADBEEF}) begin
      $display("FAIL pipe_one_cycle: got %b/%h/%h expected 0/03/deadbeef", o_wr_en, o_wr_addr, o_wr_data);
      miscompares++;
    end
  endtask

  task automatic test_busy_track();
    i_rs1 = 7; i_rs2 = 0;
    issue(7);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_rs_busy !== 1'b1) begin
        $display("FAIL busy_wait%0d: got %b expected 1", i, o_rs_busy);
        miscompares++;
      end
      step();
    end
    i_mc_valid = 1; i_mc_rd = 7; i_mc_data = 32'h12;
    step();
    i_mc_valid = 0;
    vectors++;
    if ({o_rs_busy, o_wr_en} !== 2'b10) begin
      $display("FAIL busy_pushed: got busy/wr_en=%b expected 10", {o_rs_busy, o_wr_en});
      miscompares++;
    end
    step();
    vectors++;
    if ({o_rs_busy, o_wr_en, o_wr_addr, o_wr_data} !== {1'b0, 1'b1, 5'd7, 32'h12}) begin
      $display("FAIL busy_clear: got busy=%b wr=%b/%h/%h expected 0 1/07/00000012",
               o_rs_busy, o_wr_en, o_wr_addr, o_wr_data);
      miscompares++;
    end
    step();
    vectors++;
    if ({o_rs_busy, o_wr_en, o_err} !== 3'b000) begin
      $display("FAIL busy_after: got busy/wr_en/err=%b expected 000", {o_rs_busy, o_wr_en, o_err});
      miscompares++;
    end
  endtask

  task automatic test_starve();
    i_rs1 = 10;
    issue(10);
    i_mc_valid = 1; i_mc_rd = 10; i_mc_data = 32'hAA;
    step();
    i_mc_valid = 0;
    for (int i = 0; i < 4; i++) begin
      i_pipe_valid = 1; i_pipe_rd = 5'(i + 1); i_pipe_data = 32'h100 + i;
      step();
      vectors++;
      if ({o_wr_en, o_wr_addr, o_wr_data, o_pipe_stall} !== {1'b1, 5'(i + 1), 32'h100 + i, i == 3}) begin
        $display("FAIL starve_pipe%0d: got %b/%h/%h stall=%b expected 1/%h/%h stall=%b",
                 i, o_wr_en, o_wr_addr, o_wr_data, o_pipe_stall, i + 1, 32'h100 + i, i == 3);
        miscompares++;
      end
    end
    i_pipe_rd = 5; i_pipe_data = 32'h104;
    step();
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_pipe_stall, o_rs_busy} !== {1'b1, 5'd10, 32'hAA, 1'b0, 1'b0}) begin
      $display("FAIL starve_drain: got %b/%h/%h stall=%b busy=%b expected 1/0a/000000aa stall=0 busy=0",
               o_wr_en, o_wr_addr, o_wr_data, o_pipe_stall, o_rs_busy);
      miscompares++;
    end
    step();
    i_pipe_valid = 0;
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_pipe_stall} !== {1'b1, 5'd5, 32'h104, 1'b0}) begin
      $display("FAIL starve_held: got %b/%h/%h stall=%b expected 1/05/00000104 stall=0",
               o_wr_en, o_wr_addr, o_wr_data, o_pipe_stall);
      miscompares++;
    end
    step();
  endtask

  task automatic test_fifo_full();
    logic [36:0] exp_wr [3];
    exp_wr[0] = {5'd11, 32'hB1};
    exp_wr[1] = {5'd12, 32'hB2};
    exp_wr[2] = {5'd13, 32'hB3};
    issue(11); issue(12); issue(13);
    i_pipe_valid = 1; i_pipe_rd = 0; i_pipe_data = 32'h5A;
    i_mc_valid = 1; i_mc_rd = 11; i_mc_data = 32'hB1;
    step();
    i_mc_rd = 12; i_mc_data = 32'hB2;
    step();
    i_mc_rd = 13; i_mc_data = 32'hB3;
    #1;
    vectors++;
    if ({o_mc_ready, o_wr_en} !== 2'b00) begin
      $display("FAIL full_ready: got ready/wr_en=%b expected 00", {o_mc_ready, o_wr_en});
      miscompares++;
    end
    step();
    i_pipe_valid = 0;
    #1;
    vectors++;
    if (o_mc_ready !== 1'b0) begin
      $display("FAIL full_pop_cycle_ready: got %b expected 0", o_mc_ready);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) i_mc_valid = 0;
      vectors++;
      if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, exp_wr[i]}) begin
        $display("FAIL fifo_order%0d: got %b/%h/%h expected 1/%h/%h",
                 i, o_wr_en, o_wr_addr, o_wr_data, exp_wr[i][36:32], exp_wr[i][31:0]);
        miscompares++;
      end
    end
    step();
    vectors++;
    if ({o_wr_en, o_mc_ready, o_err} !== 3'b010) begin
      $display("FAIL fifo_drained: got wr_en/ready/err=%b expected 010", {o_wr_en, o_mc_ready, o_err});
      miscompares++;
    end
  endtask

  task automatic test_rd0_and_err();
    i_pipe_valid = 1; i_pipe_rd = 0; i_pipe_data = 32'h55;
    step();
    i_pipe_valid = 0;
    vectors++;
    if (o_wr_en !== 1'b0) begin
      $display("FAIL rd0_pipe: got wr_en=%b expected 0", o_wr_en);
      miscompares++;
    end
    issue(0);
    i_mc_valid = 1; i_mc_rd = 0; i_mc_data = 32'h66;
    step();
    i_mc_valid = 0;
    step();
    vectors++;
    if ({o_wr_en, o_mc_ready, o_err} !== 3'b010) begin
      $display("FAIL rd0_mc: got wr_en/ready/err=%b expected 010", {o_wr_en, o_mc_ready, o_err});
      miscompares++;
    end
    issue(9);
    vectors++;
    if (o_err !== 1'b0) begin
      $display("FAIL err_first_issue: got %b expected 0", o_err);
      miscompares++;
    end
    issue(9);
    vectors++;
    if (o_err !== 1'b1) begin
      $display("FAIL err_waw_issue: got %b expected 1", o_err);
      miscompares++;
    end
    step(); step();
    vectors++;
    if (o_err !== 1'b1) begin
      $display("FAIL err_sticky: got %b expected 1", o_err);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_burst();
    issue(5); issue(6);
    i_rs1 = 5; i_rs2 = 6;
    i_pipe_valid = 1; i_pipe_rd = 0;
    i_mc_valid = 1; i_mc_rd = 5; i_mc_data = 32'hC5;
    step();
    i_mc_rd = 6; i_mc_data = 32'hC6;
    step();
    i_mc_valid = 0;
    vectors++;
    if ({o_mc_ready, o_rs_busy} !== 2'b01) begin
      $display("FAIL burst_full: got ready/busy=%b expected 01", {o_mc_ready, o_rs_busy});
      miscompares++;
    end
    idle();
    i_reset_n = 0;
    step();
    i_reset_n = 1;
    vectors++;
    if ({o_mc_ready, o_wr_en, o_rs_busy, o_err} !== 4'b1000) begin
      $display("FAIL reset_mid: got ready/wr_en/busy/err=%b expected 1000",
               {o_mc_ready, o_wr_en, o_rs_busy, o_err});
      miscompares++;
    end
    step();
    vectors++;
    if ({o_wr_en, o_mc_ready} !== 2'b01) begin
      $display("FAIL reset_dropped: got wr_en/ready=%b expected 01", {o_wr_en, o_mc_ready});
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_busy_track();
    test_starve();
    test_fifo_full();
    test_rd0_and_err();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
